// File: rtl/ask4_pkg.sv
// Shared 4-ASK definitions: FSM state encoding, thermometer level codes,
// and the level <-> symbol mapping used by both the transmitter and the receiver.
package ask4_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE   = 2'd0,
        HUNT        = 2'd1,
        CHECK_START = 2'd2,
        DATA        = 2'd3
    } rx_state_t;

    localparam int unsigned THERM_W = 3;
    localparam int unsigned SYM_W   = 2;

    localparam logic [THERM_W-1:0] THERM_0 = 3'b000;
    localparam logic [THERM_W-1:0] THERM_1 = 3'b001;
    localparam logic [THERM_W-1:0] THERM_2 = 3'b011;
    localparam logic [THERM_W-1:0] THERM_3 = 3'b111;

    typedef struct packed {
        logic             ok;
        logic [SYM_W-1:0] sym;
    } decode_t;

    // Thermometer code to 2-bit symbol; any non-thermometer pattern is flagged invalid.
    function automatic decode_t decode(input logic [THERM_W-1:0] therm);
        decode_t r;
        r.ok  = 1'b1;
        r.sym = 2'd0;
        case (therm)
            THERM_0: r.sym = 2'd0;
            THERM_1: r.sym = 2'd1;
            THERM_2: r.sym = 2'd2;
            THERM_3: r.sym = 2'd3;
            default: r.ok  = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [THERM_W-1:0] encode(input logic [SYM_W-1:0] sym);
        logic [THERM_W-1:0] t;
        case (sym)
            2'd0:    t = THERM_0;
            2'd1:    t = THERM_1;
            2'd2:    t = THERM_2;
            default: t = THERM_3;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous level signals.
module sync_2ff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ask4_symbol_rx.sv
// 4-ASK byte receiver: a 111 start symbol followed by four 2-bit symbols, MSB first,
// each sampled mid-symbol using a free-running symbol-period counter.
module ask4_symbol_rx
    import ask4_pkg::*;
#(
    parameter int unsigned SYM_DIV = 62500
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   comp,
    output logic [7:0]   sample,
    output logic         sample_valid,
    output logic         sym_err,
    output logic         busy
);

    localparam int unsigned CNT_W = $clog2(SYM_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(SYM_DIV / 2 - 1);

    logic [THERM_W-1:0] line;
    rx_state_t          state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         nsym;
    logic [5:0]         shreg;
    logic [1:0]         fill;
    logic               at_sp_c;
    decode_t            dec_c;

    sync_2ff #(.W(THERM_W)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (comp),
        .q   (line)
    );

    // The counter is cleared at the cycle after t, so cnt == SYM_DIV/2-1 marks t + k*SYM_DIV + SYM_DIV/2.
    assign at_sp_c = (cnt == CNT_MID);
    assign dec_c   = decode(line);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= WAIT_IDLE;
            cnt          <= '0;
            nsym         <= '0;
            shreg        <= '0;
            fill         <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            sym_err      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            sym_err      <= 1'b0;
            // Line holds reset zeros until the synchronizer has refilled; do not mistake that for idle.
            fill         <= {fill[0], 1'b1};

            if (state == CHECK_START || state == DATA) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            end

            case (state)
                WAIT_IDLE: begin
                    if (fill[1] && line == THERM_0) begin
                        state <= HUNT;
                    end
                end
                HUNT: begin
                    if (line == THERM_3) begin
                        state <= CHECK_START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CHECK_START: begin
                    if (at_sp_c) begin
                        if (line == THERM_3) begin
                            state <= DATA;
                            nsym  <= '0;
                        end else begin
                            state <= HUNT;
                            busy  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (at_sp_c) begin
                        if (!dec_c.ok) begin
                            sym_err <= 1'b1;
                            state   <= WAIT_IDLE;
                            busy    <= 1'b0;
                        end else if (nsym == 2'd3) begin
                            sample       <= {shreg, dec_c.sym};
                            sample_valid <= 1'b1;
                            state        <= WAIT_IDLE;
                            busy         <= 1'b0;
                        end else begin
                            shreg <= {shreg[3:0], dec_c.sym};
                            nsym  <= nsym + 2'd1;
                        end
                    end
                end
                default: begin
                    state <= WAIT_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ask4_symbol_rx.sv
// Scoreboard bench for ask4_symbol_rx: frames are built from bytes, expected pulses
// (value and cycle) are queued at stimulus time and matched by a negedge monitor.
module tb_ask4_symbol_rx;

    localparam int SD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] comp;
    logic [7:0] sample;
    logic       sample_valid;
    logic       sym_err;
    logic       busy;

    typedef struct {
        bit       is_err;
        bit [7:0] val;
        int       due;
    } exp_t;

    exp_t       sbq[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    bit [7:0]   model_sample = 8'h00;
    logic [2:0] therm_tab [4] = '{3'b000, 3'b001, 3'b011, 3'b111};
    logic [2:0] bad_tab   [4] = '{3'b010, 3'b100, 3'b101, 3'b110};

    ask4_symbol_rx #(.SYM_DIV(SD)) dut (
        .clk          (clk),
        .rst          (rst),
        .comp         (comp),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sym_err      (sym_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && (sample_valid || sym_err)) begin
            exp_t e;
            chk("pulse_exclusive", int'(sample_valid && sym_err), 0);
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pulse: valid=%0b err=%0b sample=0x%0h at cycle %0d",
                         sample_valid, sym_err, sample, cyc);
            end else begin
                e = sbq.pop_front();
                chk("pulse_is_err", int'(sym_err), int'(e.is_err));
                chk("pulse_cycle", cyc, e.due);
                if (!e.is_err) begin
                    model_sample = e.val;
                    chk("sample_value", int'(sample), int'(e.val));
                end else begin
                    chk("sample_held", int'(sample), int'(model_sample));
                end
            end
        end
    end

    task automatic drive(input logic [2:0] v, input int n);
        comp = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start symbol then four data symbols MSB-first; bad_sym (1..4) replaces that symbol with bad_code.
    task automatic send_frame(input bit [7:0] b, input int bad_sym, input logic [2:0] bad_code);
        exp_t e;
        int   start;
        int   sym;
        start = cyc;
        if (bad_sym < 1) begin
            e = '{is_err: 1'b0, val: b, due: start + 2 + SD/2 + 4*SD + 1};
        end else begin
            e = '{is_err: 1'b1, val: b, due: start + 2 + SD/2 + bad_sym*SD + 1};
        end
        sbq.push_back(e);
        drive(3'b111, SD);
        for (int k = 1; k <= 4; k++) begin
            sym = int'((b >> (8 - 2*k)) & 8'h03);
            if (k == bad_sym) begin
                drive(bad_code, SD);
                drive(3'b111, 2*SD);
                return;
            end
            drive(therm_tab[sym], SD);
        end
    endtask

    initial begin
        rst  = 1'b1;
        comp = 3'b111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sample", int'(sample), 0);
        chk("rst_valid", int'(sample_valid), 0);
        chk("rst_err", int'(sym_err), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Power-up with line stuck at 111
        drive(3'b111, 3*SD);
        chk("stuck_busy", int'(busy), 0);
        drive(3'b000, 8);
        send_frame(8'hA5, 0, 3'b000);
        drive(3'b000, 8);

        send_frame(8'hB4, 0, 3'b000);
        drive(3'b000, 8);

        // Short start glitch must be rejected at the start-check point
        drive(3'b111, 4);
        chk("glitch_busy_high", int'(busy), 1);
        drive(3'b000, SD);
        chk("glitch_busy_low", int'(busy), 0);
        send_frame(8'h1E, 0, 3'b000);
        drive(3'b000, 8);

        send_frame(8'h3C, 2, 3'b101);
        chk("err_busy", int'(busy), 0);
        drive(3'b000, 8);
        send_frame(8'h77, 0, 3'b000);

        drive(3'b000, 8);
        send_frame(8'hFF, 0, 3'b000);
        drive(3'b000, SD);
        send_frame(8'h00, 0, 3'b000);
        drive(3'b000, 8);

        // Reset mid-frame during data symbol 3
        drive(3'b111, SD);
        drive(therm_tab[1], SD);
        drive(therm_tab[2], SD);
        comp = therm_tab[3];
        repeat (SD/2) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        chk("midrst_sample", int'(sample), 0);
        chk("midrst_valid", int'(sample_valid), 0);
        chk("midrst_err", int'(sym_err), 0);
        chk("midrst_busy", int'(busy), 0);
        model_sample = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        drive(3'b111, 4*SD);
        chk("postrst_busy", int'(busy), 0);
        drive(3'b000, 8);
        send_frame(8'h5A, 0, 3'b000);

        // Randomized mix of good frames, glitches and bad codes
        for (int i = 0; i < 24; i++) begin
            int kind;
            drive(3'b000, $urandom_range(4, 20));
            kind = $urandom_range(0, 5);
            if (kind == 0) begin
                drive(3'b111, $urandom_range(1, 7));
                drive(3'b000, SD);
            end else if (kind == 1) begin
                send_frame(8'($urandom), $urandom_range(1, 4), bad_tab[$urandom_range(0, 3)]);
            end else begin
                send_frame(8'($urandom), 0, 3'b000);
            end
        end

        drive(3'b000, 2*SD);
        chk("queue_drained", sbq.size(), 0);
        chk("final_sample", int'(sample), int'(model_sample));
        chk("final_busy", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ask4_symbol_rx.md
ASK4_SYMBOL_RX -- requirements
Module: ask4_symbol_rx

Interface
REQ-001 SHALL have parameter SYM_DIV, default 62500: clk cycles per 4-ASK symbol (800 Hz at 50 MHz); legal values are even and at least 8.
REQ-002 SHALL have port clk  input  1  system clock, the only clock.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port comp  input  3  asynchronous thermometer comparator outputs of the envelope detector; bit0 is the lowest threshold.
REQ-005 SHALL have port sample  output  8  last correctly received 8-bit sample.
REQ-006 SHALL have port sample_valid  output  1  one-cycle pulse when sample updates.
REQ-007 SHALL have port sym_err  output  1  one-cycle pulse on an invalid code at a sample point.
REQ-008 SHALL have port busy  output  1  high while in CHECK_START or DATA.

Function
REQ-009 SHALL pass comp through a 2-FF synchronizer; "line" below means the synchronized value.
REQ-010 SHALL decode the line as follows: 000->00, 001->01, 011->10, 111->11; 010, 100, 101 and 110 are invalid.
REQ-011 SHALL use states WAIT_IDLE, HUNT, CHECK_START, DATA.
REQ-012 In WAIT_IDLE, the block SHALL move to HUNT on the first cycle the line equals 000.
REQ-013 In HUNT, the block SHALL move to CHECK_START on the first cycle the line equals 111 (cycle t) and clear the symbol counter.
REQ-014 In CHECK_START, the block SHALL sample at t+SYM_DIV/2, going to DATA if the line is 111 and to HUNT otherwise, with no pulse in either case.
REQ-015 In DATA, the block SHALL sample at t+SYM_DIV/2+k*SYM_DIV for k=1..4 and shift each decoded 2-bit symbol in MSB-first, so symbol 1 lands in sample bits [7:6].
REQ-016 On a valid 4th symbol, the block SHALL load sample and pulse sample_valid one cycle after that sample point, then go to WAIT_IDLE.
REQ-017 On an invalid code at any data sample point, the block SHALL pulse sym_err one cycle later, discard the partial byte, leave sample unchanged, and go to WAIT_IDLE.
REQ-018 Line activity between sample points SHALL be ignored, since only sample points are evaluated.
REQ-019 The symbol counter SHALL wrap from SYM_DIV-1 to 0, with width $clog2(SYM_DIV).
REQ-020 sample_valid and sym_err SHALL never be high in the same cycle.
REQ-021 Latency from raw comp edge to the timing origin t SHALL be exactly 2 cycles, accounting for the synchronizer.

Reset
REQ-022 While rst is high, state SHALL be WAIT_IDLE, and the synchronizer, counters, shift register, sample, sample_valid, sym_err and busy SHALL all be 0.
REQ-023 Reset asserted mid-frame SHALL discard the frame, emit no pulse, and require a fresh 000 before the next hunt.

Structure
REQ-024 A shared package ask4_pkg SHALL hold the state encoding, the four valid thermometer constants, and the decode function; the 4-ASK transmitter SHALL reuse these constants.
REQ-025 The synchronizer SHALL be a separate sub-module sync_2ff, parameterized by width, instantiated with width 3.
REQ-026 The remainder SHALL be one FSM plus counters, with no derived clocks and all timing done by clock enables.

Verification (SYM_DIV=16)
REQ-027 Idle 000, then start 111 followed by symbols 10, 11, 01, 00 of 16 cycles each -> sample=0xB4, with sample_valid exactly 2+8+64+1 cycles after the raw 111 edge.
REQ-028 Idle 000, then a 111 glitch of 4 cycles, then 000 -> no pulses, busy returns to 0, and the following valid frame carrying 0x1E is received.
REQ-029 Code 101 during data symbol 2 -> one sym_err pulse, no sample_valid, sample keeps its prior value, and the next frame is accepted only after 000.
REQ-030 rst pulsed during data symbol 3 -> all outputs 0 immediately, no pulse, and line held at 111 afterwards yields nothing until 000 is seen.
REQ-031 Two frames 0xFF and 0x00 separated by one 000 symbol -> two sample_valid pulses with the correct values.
REQ-032 Power-up with line stuck at 111 -> no activity until 000 appears, then a normal frame carrying 0xA5 is received.
